fp_divider_seq: RTL and testbench



---
 rtl/fp_divider_seq_if.sv | 25 ++
 rtl/fp_divider_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp_divider_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/fp_divider_seq_if.sv
// fp_divider_seq_if
//   Handshake bundle for the sequential FP32 divider.
//   in_valid / in_ready : operand transfer (A dividend, B divisor, FP32)
//   out_valid / out_ready : result transfer (Out quotient, FP32)
//   master : the producer/consumer side (drives operands, accepts results)
//   slave  : the divider itself
interface fp_divider_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/fp_divider_seq.sv
// fp_divider_seq
//   Sequential IEEE-754 binary32 divider, Out = A / B. The mantissa quotient
//   is produced by a restoring shift-subtract loop, one bit per clock
//   (25 bits), followed by a one-bit normalise with truncation. Special
//   operands (NaN, inf, zero/denormal) bypass the loop and finish in one cycle.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : fp_divider_seq_if.slave (in_valid/in_ready/A/B, out_valid/out_ready/Out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready=1, waiting for operands
//   DIV   | one quotient bit per cycle, counter 24 down to 0
//   NORM  | normalise quotient, pack and register Out
//   DONE  | out_valid=1, Out held until out_ready
module fp_divider_seq (
    input  logic             clk,
    input  logic             rst_n,
    fp_divider_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [24:0]        rem;
    logic [24:0]        quo;
    logic [23:0]        mb;
    logic [4:0]         cnt;
    logic signed [9:0]  exp_r;
    logic               sign_r;
    logic [31:0]        out_r;

    // ---------------- operand decode (used only in IDLE) ----------------
    logic [7:0]  ea, eb;
    logic        sign_in;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        special;
    logic [31:0] special_res;

    always_comb begin
        ea          = bus.A[30:23];
        eb          = bus.B[30:23];
        sign_in     = bus.A[31] ^ bus.B[31];
        a_nan       = (&ea) && (|bus.A[22:0]);
        b_nan       = (&eb) && (|bus.B[22:0]);
        a_inf       = (&ea) && !(|bus.A[22:0]);
        b_inf       = (&eb) && !(|bus.B[22:0]);
        special     = 1'b0;
        special_res = 32'h0;
        // Priority order matters: NaN-producing cases first, then inf, then zero.
        // A zero exponent means zero or denormal; both are treated as zero.
        if (a_nan || b_nan) begin
            special     = 1'b1;
            special_res = 32'h7FC0_0000;
        end else if (a_inf && b_inf) begin
            special     = 1'b1;
            special_res = 32'h7FC0_0000;
        end else if (ea == 8'd0 && eb == 8'd0) begin
            special     = 1'b1;
            special_res = 32'h7FC0_0000;
        end else if (a_inf) begin
            special     = 1'b1;
            special_res = {sign_in, 8'hFF, 23'd0};
        end else if (eb == 8'd0) begin
            special     = 1'b1;
            special_res = {sign_in, 8'hFF, 23'd0};
        end else if (ea == 8'd0) begin
            special     = 1'b1;
            special_res = {sign_in, 31'd0};
        end else if (b_inf) begin
            special     = 1'b1;
            special_res = {sign_in, 31'd0};
        end
    end

    // ---------------- restoring divide step ----------------
    logic        q_bit;
    logic [24:0] rem_sub;

    always_comb begin
        q_bit   = (rem >= {1'b0, mb});
        rem_sub = q_bit ? (rem - {1'b0, mb}) : rem;
    end

    // ---------------- normalise / pack ----------------
    // exp_r already holds Ea-Eb+126; a quotient with bit 24 set is in [2,4)
    // relative to the 2^23 scale and needs one more in the exponent.
    logic signed [9:0] e_final;
    logic [22:0]       norm_mant;
    logic [31:0]       norm_res;

    always_comb begin
        e_final   = exp_r + $signed({9'd0, quo[24]});
        norm_mant = quo[24] ? quo[23:1] : quo[22:0];
        if (e_final <= 10'sd0) begin
            norm_res = {sign_r, 31'd0};
        end else if (e_final >= 10'sd255) begin
            norm_res = {sign_r, 8'hFF, 23'd0};
        end else begin
            norm_res = {sign_r, e_final[7:0], norm_mant};
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = special ? DONE : DIV;
                end
            end
            DIV: begin
                if (cnt == 5'd0) begin
                    state_nxt = NORM;
                end
            end
            NORM: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.Out       = out_r;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= 25'd0;
            quo    <= 25'd0;
            mb     <= 24'd0;
            cnt    <= 5'd0;
            exp_r  <= 10'sd0;
            sign_r <= 1'b0;
            out_r  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= sign_in;
                        mb     <= {1'b1, bus.B[22:0]};
                        rem    <= {2'b01, bus.A[22:0]};
                        quo    <= 25'd0;
                        cnt    <= 5'd24;
                        exp_r  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
                        if (special) begin
                            out_r <= special_res;
                        end
                    end
                end
                DIV: begin
                    quo <= {quo[23:0], q_bit};
                    rem <= rem_sub << 1;
                    if (cnt != 5'd0) begin
                        cnt <= cnt - 5'd1;
                    end
                end
                NORM: begin
                    out_r <= norm_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
module tb_fp_divider_seq;

    localparam int LAT_NORMAL  = 26;
    localparam int LAT_SPECIAL = 0;   // out_valid already visible right after the accept edge
    localparam int WAIT_LIMIT  = 200;

    logic clk;
    logic rst_n;

    fp_divider_seq_if bus ();

    fp_divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] dropped;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operand pair and push its expected result; returns just after the accept edge.
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] want);
        @(negedge clk);
        check_val({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        sb_q.push_back(want);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = $urandom();
        bus.B        = $urandom();
    endtask

    // Wait for out_valid, checking latency, busy in_ready, and the scoreboard entry.
    task automatic wait_result(input string tag, input int lat);
        int   edges;
        logic busy_ok;
        logic [31:0] want;
        edges   = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && edges < WAIT_LIMIT) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check_val({tag, "_lat"}, edges, lat);
        if (lat > 0) check_val({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        if (sb_q.size() > 0) begin
            want = sb_q.pop_front();
            check_val({tag, "_out"}, bus.Out, want);
        end else begin
            check_val({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check_val({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int lat);
        start_op(tag, a, b, want);
        wait_result(tag, lat);
        consume(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 32'h0;
        bus.B         = 32'h0;
        bus.out_ready = 1'b0;
        #12;
        check_val("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_out",       bus.Out,                32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal divisions
        run_op("div_6_2",   32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, LAT_NORMAL);
        run_op("div_1_3",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORMAL);
        run_op("div_15_15", 32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0000, LAT_NORMAL);
        run_op("div_m7_05", 32'hC0E0_0000, 32'h3F00_0000, 32'hC160_0000, LAT_NORMAL);

        // Special operands
        run_op("sp_div0",   32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, LAT_SPECIAL);
        run_op("sp_0_0",    32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, LAT_SPECIAL);
        run_op("sp_b_inf",  32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, LAT_SPECIAL);
        run_op("sp_nan",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, LAT_SPECIAL);
        run_op("sp_a_inf",  32'h7F80_0000, 32'hBF80_0000, 32'hFF80_0000, LAT_SPECIAL);
        run_op("sp_inf_inf",32'hFF80_0000, 32'h7F80_0000, 32'h7FC0_0000, LAT_SPECIAL);

        // Exponent range limits
        run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, LAT_NORMAL);
        run_op("overflow",  32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, LAT_NORMAL);

        // Backpressure: result held, new operands ignored
        start_op("bp", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        wait_result("bp", LAT_NORMAL);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.A        = 32'h3F80_0000;
            bus.B        = 32'h0000_0000;
            @(posedge clk);
            #1;
            check_val("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check_val("bp_hold_out",   bus.Out,                32'h4040_0000);
            check_val("bp_hold_ready", {31'd0, bus.in_ready},  32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_val("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
        check_val("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_no_ghost", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of the loop
        start_op("rst_mid", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
        check_val("rst_mid_ready", {31'd0, bus.in_ready},  32'd1);
        check_val("rst_mid_out",   bus.Out,                32'h0);
        dropped = sb_q.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, LAT_NORMAL);

        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
